// File: rtl/cardhandling.sv
// cardhandling: card session controller.
// Holds a small in-register account table, authenticates a card by password
// (at most three consecutive tries) and commits balance updates while a
// session is authenticated.
module cardhandling #(
  parameter int card_width     = 6,
  parameter int password_width = 16,
  parameter int balance_width  = 20,
  parameter int users_num      = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [card_width-1:0]     card_number,
  input  logic                      card_in,
  input  logic                      card_out,
  input  logic                      op_done,
  input  logic [balance_width-1:0]  updated_balance,
  input  logic [password_width-1:0] password_input,
  output logic [balance_width-1:0]  balance,
  output logic                      psw_en,
  output logic                      wrong_psw
);

  localparam int IdxW = (users_num > 1) ? $clog2(users_num) : 1;
  localparam logic [password_width-1:0] PswBase = password_width'(32'hAAAA);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PSW,
    AUTH
  } state_e;

  state_e                   state_q;
  logic [IdxW-1:0]          idx_q;
  logic [1:0]               attempts_q;
  logic [balance_width-1:0] acct_q [users_num];
  logic [balance_width-1:0] balance_q;
  logic                     psw_en_q;
  logic                     wrong_psw_q;

  logic                     cardHit;
  logic [IdxW-1:0]          cardIdx;
  logic                     pswMatch;

  // Card lookup: entry i owns card number i+1, so card 0 never matches.
  always_comb begin
    cardHit = 1'b0;
    cardIdx = '0;
    for (int i = 0; i < users_num; i++) begin
      if (card_number == card_width'(i + 1)) begin
        cardHit = 1'b1;
        cardIdx = IdxW'(i);
      end
    end
  end

  // Stored password of the latched entry is a fixed pattern XOR its index.
  assign pswMatch = (password_input == (PswBase ^ password_width'(idx_q)));

  // Session FSM, account table and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      attempts_q  <= '0;
      balance_q   <= '0;
      psw_en_q    <= 1'b0;
      wrong_psw_q <= 1'b0;
      for (int i = 0; i < users_num; i++) begin
        acct_q[i] <= balance_width'(1000 * (i + 1));
      end
    end else begin
      wrong_psw_q <= 1'b0;
      case (state_q)
        IDLE: begin
          balance_q <= '0;
          psw_en_q  <= 1'b0;
          if (card_in && cardHit) begin
            idx_q      <= cardIdx;
            attempts_q <= '0;
            state_q    <= WAIT_PSW;
          end
        end
        WAIT_PSW: begin
          if (card_out) begin
            attempts_q <= '0;
            state_q    <= IDLE;
          end else if (pswMatch) begin
            attempts_q <= '0;
            psw_en_q   <= 1'b1;
            balance_q  <= acct_q[idx_q];
            state_q    <= AUTH;
          end else begin
            wrong_psw_q <= 1'b1;
            if (attempts_q == 2'd2) begin
              attempts_q <= '0;
              state_q    <= IDLE;
            end else begin
              attempts_q <= attempts_q + 2'd1;
            end
          end
        end
        AUTH: begin
          if (op_done) begin
            acct_q[idx_q] <= updated_balance;
            balance_q     <= updated_balance;
          end
          if (card_out) begin
            balance_q <= '0;
            psw_en_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign balance   = balance_q;
  assign psw_en    = psw_en_q;
  assign wrong_psw = wrong_psw_q;

endmodule

// File: tb/tb_cardhandling.sv
// tb_cardhandling: scoreboard bench for cardhandling.
// The stimulus process steps a behavioural account/session model and queues
// the expected outputs; a negedge monitor pops and compares them.
module tb_cardhandling;

   typedef struct packed {
      logic [19:0] bal;
      logic        psw;
      logic        wrong;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [5:0]  cardNumber;
   logic        cardIn;
   logic        cardOut;
   logic        opDone;
   logic [19:0] updatedBalance;
   logic [15:0] passwordInput;
   logic [19:0] balance;
   logic        pswEn;
   logic        wrongPsw;

   int nCompared;
   int nMismatched;

   exp_t  expQ[$];
   string tagQ[$];
   exp_t  monExp;
   string monTag;

   // Behavioural model: session 0 = no card, 1 = awaiting password, 2 = authenticated.
   int          mSession;
   int          mUser;
   int          mMisses;
   logic [19:0] mBal[10];
   logic [19:0] mOutBal;
   logic        mOutPsw;

   cardhandling dut (
      .clk            (clk),
      .rst            (rst),
      .card_number    (cardNumber),
      .card_in        (cardIn),
      .card_out       (cardOut),
      .op_done        (opDone),
      .updated_balance(updatedBalance),
      .password_input (passwordInput),
      .balance        (balance),
      .psw_en         (pswEn),
      .wrong_psw      (wrongPsw)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares the DUT outputs against one expected record.
   task automatic checkOutput(input string tag, input exp_t e);
      nCompared++;
      if (balance !== e.bal || pswEn !== e.psw || wrongPsw !== e.wrong) begin
         nMismatched++;
         $display("[TB] FAIL %s t=%0t: got balance=%0d psw_en=%b wrong_psw=%b, want balance=%0d psw_en=%b wrong_psw=%b",
                  tag, $time, balance, pswEn, wrongPsw, e.bal, e.psw, e.wrong);
      end
   endtask

   // Monitor: after every rising edge, check the output the model predicted for it.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         monTag = tagQ.pop_front();
         checkOutput(monTag, monExp);
      end
   end

   function automatic void modelReset();
      mSession = 0;
      mUser    = 0;
      mMisses  = 0;
      mOutBal  = '0;
      mOutPsw  = 1'b0;
      for (int i = 0; i < 10; i++) mBal[i] = 20'(1000 * (i + 1));
   endfunction

   // One clock edge of the session rules; returns the outputs seen after it.
   function automatic exp_t modelStep(input int cn, input logic cin, input logic cout,
                                      input logic op, input logic [19:0] ub,
                                      input logic [15:0] pw);
      exp_t e;
      logic wrong;
      wrong = 1'b0;
      if (mSession == 0) begin
         mOutBal = '0;
         mOutPsw = 1'b0;
         if (cin && cn >= 1 && cn <= 10) begin
            mUser    = cn - 1;
            mMisses  = 0;
            mSession = 1;
         end
      end else if (mSession == 1) begin
         if (cout) begin
            mSession = 0;
         end else if (pw == (16'hAAAA ^ 16'(mUser))) begin
            mSession = 2;
            mMisses  = 0;
            mOutPsw  = 1'b1;
            mOutBal  = mBal[mUser];
         end else begin
            wrong   = 1'b1;
            mMisses = mMisses + 1;
            if (mMisses == 3) mSession = 0;
         end
      end else begin
         if (op) begin
            mBal[mUser] = ub;
            mOutBal     = ub;
         end
         if (cout) begin
            mSession = 0;
            mOutBal  = '0;
            mOutPsw  = 1'b0;
         end
      end
      e.bal   = mOutBal;
      e.psw   = mOutPsw;
      e.wrong = wrong;
      return e;
   endfunction

   // Drives one cycle of inputs, queues the predicted response, advances to after the edge.
   task automatic applyStimulus(input string tag, input int cn, input logic cin,
                                input logic cout, input logic op,
                                input logic [19:0] ub, input logic [15:0] pw);
      cardNumber     = 6'(cn);
      cardIn         = cin;
      cardOut        = cout;
      opDone         = op;
      updatedBalance = ub;
      passwordInput  = pw;
      expQ.push_back(modelStep(cn, cin, cout, op, ub, pw));
      tagQ.push_back(tag);
      @(negedge clk);
      #1;
   endtask

   // Asserts reset mid-cycle, checks outputs clear without waiting for an edge.
   task automatic applyReset(input string tag);
      exp_t z;
      z = '0;
      rst = 1'b0;
      #1;
      checkOutput({tag, "_immediate"}, z);
      modelReset();
      cardIn  = 1'b0;
      cardOut = 1'b0;
      opDone  = 1'b0;
      expQ.push_back(z);
      tagQ.push_back({tag, "_held"});
      @(negedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic login(input string tag, input int cn);
      applyStimulus({tag, "_card"}, cn, 1'b1, 1'b0, 1'b0, 20'd0, 16'h0);
      applyStimulus({tag, "_psw"}, cn, 1'b0, 1'b0, 1'b0, 20'd0, 16'hAAAA ^ 16'(cn - 1));
   endtask

   initial begin
      int          cn;
      logic        cin, cout, op;
      logic [19:0] ub;
      logic [15:0] pw;

      nCompared      = 0;
      nMismatched    = 0;
      rst            = 1'b1;
      cardNumber     = '0;
      cardIn         = 1'b0;
      cardOut        = 1'b0;
      opDone         = 1'b0;
      updatedBalance = '0;
      passwordInput  = '0;
      modelReset();

      @(negedge clk);
      #1;
      applyReset("reset");
      applyStimulus("idle_after_reset", 0, 1'b0, 1'b0, 1'b0, 20'd0, 16'h0);

      // Card 1 with the correct password authenticates with balance 1000.
      login("auth1", 1);
      applyStimulus("auth1_hold", 1, 1'b0, 1'b0, 1'b0, 20'd0, 16'h0);

      // Balance write, logout, re-login shows the written value.
      applyStimulus("write_cccc", 1, 1'b0, 1'b0, 1'b1, 20'hCCCCC, 16'h0);
      applyStimulus("logout1", 1, 1'b0, 1'b1, 1'b0, 20'd0, 16'h0);
      login("reauth1", 1);
      applyStimulus("logout1b", 1, 1'b0, 1'b1, 1'b0, 20'd0, 16'h0);

      // Three wrong passwords on card 3 drop back to idle.
      applyStimulus("card3", 3, 1'b1, 1'b0, 1'b0, 20'd0, 16'h0000);
      for (int i = 0; i < 4; i++) applyStimulus("wrong3", 3, 1'b0, 1'b0, 1'b0, 20'd0, 16'h0000);
      applyStimulus("wrong3_idle", 3, 1'b0, 1'b0, 1'b0, 20'd0, 16'hAAAA ^ 16'd2);

      // Card removed while waiting for password: no wrong pulse.
      applyStimulus("card5", 5, 1'b1, 1'b0, 1'b0, 20'd0, 16'h0);
      applyStimulus("card5_out", 5, 1'b0, 1'b1, 1'b0, 20'd0, 16'h1234);

      // Unknown cards are ignored.
      applyStimulus("card0", 0, 1'b1, 1'b0, 1'b0, 20'd0, 16'hAAAA);
      applyStimulus("card0_hold", 0, 1'b1, 1'b0, 1'b0, 20'd0, 16'hAAAA);
      applyStimulus("card11", 11, 1'b1, 1'b0, 1'b0, 20'd0, 16'hAAA0);
      applyStimulus("card11_hold", 11, 1'b0, 1'b0, 1'b0, 20'd0, 16'hAAA0);

      // Simultaneous write and logout still commits the write.
      login("auth_both", 1);
      applyStimulus("write_and_out", 1, 1'b0, 1'b1, 1'b1, 20'd5, 16'h0);
      login("reauth_five", 1);

      // Reset mid-session restores the default table.
      applyStimulus("write_777", 1, 1'b0, 1'b0, 1'b1, 20'd777, 16'h0);
      applyReset("reset_mid_auth");
      login("reauth_default", 1);
      applyStimulus("logout_default", 1, 1'b0, 1'b1, 1'b0, 20'd0, 16'h0);

      // Randomized traffic, biased toward correct passwords while one is awaited.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            applyReset("rand_reset");
         end else begin
            cn   = int'($urandom_range(0, 12));
            cin  = ($urandom_range(0, 1) == 1);
            cout = ($urandom_range(0, 9) == 0);
            op   = ($urandom_range(0, 2) == 0);
            ub   = 20'($urandom);
            if (mSession == 1 && $urandom_range(0, 2) != 0) pw = 16'hAAAA ^ 16'(mUser);
            else pw = 16'($urandom_range(0, 15)) ^ 16'hAAAA;
            applyStimulus("random", cn, cin, cout, op, ub, pw);
         end
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
